result_tx_ctrl: RTL



---
 rtl/result_tx_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/result_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : result_tx_ctrl
// Description : Serializes vector (BRAM stream) or scalar results to uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module result_tx_ctrl #(
    parameter int VEC_LEN = 1024,
    parameter int ADDR_W  = 10,
    parameter int RES_W   = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send_vec,
    input  logic              send_scalar,
    input  logic [RES_W-1:0]  scalar_in,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);

    localparam int c_nbytes = RES_W / 8;
    localparam int c_bl_w   = (c_nbytes > 1) ? $clog2(c_nbytes) : 1;
    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(VEC_LEN - 1);
    localparam logic [c_bl_w-1:0] c_bl_init  = c_bl_w'(c_nbytes - 1);

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_rd_wait  = 3'd1;
    localparam logic [2:0] c_rd_latch = 3'd2;
    localparam logic [2:0] c_send     = 3'd3;
    localparam logic [2:0] c_guard    = 3'd4;
    localparam logic [2:0] c_wait_tx  = 3'd5;
    localparam logic [2:0] c_done     = 3'd6;

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic              r_is_vec;
    logic [ADDR_W-1:0] r_idx;
    logic [RES_W-1:0]  r_shreg;
    logic [c_bl_w-1:0] r_bytes_left;
    logic [RES_W-1:0]  w_shifted;

    assign w_shifted = r_shreg << 8;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle: begin
                if (send_vec) begin
                    w_state_next = c_rd_wait;
                end else if (send_scalar) begin
                    w_state_next = c_send;
                end
            end
            c_rd_wait:  w_state_next = c_rd_latch;
            c_rd_latch: w_state_next = c_send;
            c_send: begin
                if (!tx_busy) begin
                    w_state_next = c_guard;
                end
            end
            c_guard:    w_state_next = c_wait_tx;
            c_wait_tx: begin
                if (!tx_busy) begin
                    if (r_is_vec && (r_idx != c_last_idx)) begin
                        w_state_next = c_rd_wait;
                    end else if (!r_is_vec && (r_bytes_left != '0)) begin
                        w_state_next = c_send;
                    end else begin
                        w_state_next = c_done;
                    end
                end
            end
            c_done:     w_state_next = c_idle;
            default:    w_state_next = c_idle;
        endcase
    end

    // Outputs are registered from the next state so busy/done line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_idle;
            r_is_vec     <= 1'b0;
            r_idx        <= '0;
            r_shreg      <= '0;
            r_bytes_left <= '0;
            mem_addr     <= '0;
            tx_data      <= '0;
            tx_start     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            busy     <= (w_state_next != c_idle);
            done     <= (w_state_next == c_done);
            tx_start <= (r_state == c_send) && !tx_busy;

            case (r_state)
                c_idle: begin
                    if (send_vec) begin
                        r_is_vec <= 1'b1;
                        r_idx    <= '0;
                        mem_addr <= '0;
                    end else if (send_scalar) begin
                        r_is_vec     <= 1'b0;
                        r_shreg      <= scalar_in;
                        r_bytes_left <= c_bl_init;
                        tx_data      <= scalar_in[RES_W-1 -: 8];
                    end
                end
                c_rd_latch: tx_data <= mem_data;
                c_wait_tx: begin
                    if (!tx_busy) begin
                        if (r_is_vec) begin
                            if (r_idx != c_last_idx) begin
                                r_idx    <= r_idx + 1'b1;
                                mem_addr <= r_idx + 1'b1;
                            end
                        end else if (r_bytes_left != '0) begin
                            r_shreg      <= w_shifted;
                            tx_data      <= w_shifted[RES_W-1 -: 8];
                            r_bytes_left <= r_bytes_left - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
